mdio_master: RTL

- Clause-22 MDIO management master (station management entity) driving the MDC/MDIO pad pair of the ADC capture ASIC.
- Used on the FPGA/bring-up side and as the bench driver to read and write the top regfile (capture_start, pktctrl_clk_div, self_test_mode, ...) over MDIO, instead of forcing register cells.
- Accepts one command at a time on a valid/ready interface.
- Serialises preamble, ST, OP, PHYAD, REGAD, TA and DATA, then returns a one-cycle response.

---
 rtl/mdio_master_if.sv | 24 ++
 rtl/mdio_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_if.sv
// rtl/mdio_master_if.sv - command/response bundle between a station-management user and mdio_master
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [4:0]  cmd_phyad;
  logic [4:0]  cmd_regad;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  // master issues commands; slave is the mdio_master block that serves them
  modport master (
    output cmd_valid, cmd_op, cmd_phyad, cmd_regad, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_phyad, cmd_regad, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO management master
// One command at a time: preamble, ST, OP, PHYAD, REGAD, TA, DATA, idle slot, one-cycle response.
module mdio_master #(
  parameter int HALF_DIV = 4,
  parameter int PRE_LEN  = 32
) (
  input  logic          clk,
  input  logic          rstn,
  mdio_master_if.slave  bus,
  output logic          mdc,
  output logic          mdio_o,
  output logic          mdio_oe,
  input  logic          mdio_i
);

  localparam logic [8:0] PH_HALF  = 9'(HALF_DIV);
  localparam logic [8:0] PH_LAST  = 9'(2 * HALF_DIV - 1);
  localparam logic [6:0] PRE_LAST = 7'((PRE_LEN > 0) ? (PRE_LEN - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_IDLE_SLOT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  ph_q, ph_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        op_q, op_d;
  logic        ta_err_q, ta_err_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        oe_q, oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        sync1_q, sync2_q;

  logic        end_slot;
  logic [31:0] frame;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= mdio_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      op_q        <= 1'b0;
      ta_err_q    <= 1'b0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      op_q        <= op_d;
      ta_err_q    <= ta_err_d;
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
    end
  end

  // Pad outputs are registered and loaded on the edge that opens a slot,
  // so they change only in the slot's first cycle (MDC falling edge).
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    op_d        = op_q;
    ta_err_d    = ta_err_q;
    mdo_d       = mdo_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rerr_d      = rerr_q;
    mdc_d       = 1'b0;

    end_slot = (ph_q == PH_LAST);
    frame    = {2'b01, (bus.cmd_op ? 2'b10 : 2'b01), bus.cmd_phyad, bus.cmd_regad,
                2'b10, (bus.cmd_op ? 16'h0000 : bus.cmd_wdata)};

    if (state_q != S_IDLE && state_q != S_DONE) begin
      ph_d = end_slot ? 9'd0 : (ph_q + 9'd1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d     = bus.cmd_op;
          ph_d     = '0;
          cnt_d    = '0;
          rx_d     = '0;
          ta_err_d = 1'b0;
          oe_d     = 1'b1;
          if (PRE_LEN > 0) begin
            state_d = S_PRE;
            tx_d    = frame;
            mdo_d   = 1'b1;
          end else begin
            state_d = S_HDR;
            tx_d    = {frame[30:0], 1'b0};
            mdo_d   = frame[31];
          end
        end
      end
      S_PRE: begin
        if (end_slot) begin
          if (cnt_q == PRE_LAST) begin
            state_d = S_HDR;
            cnt_d   = '0;
            mdo_d   = tx_q[31];
            tx_d    = {tx_q[30:0], 1'b0};
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      S_HDR: begin
        if (end_slot) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (cnt_q == 7'd13) begin
            state_d = S_TA;
            cnt_d   = '0;
            oe_d    = ~op_q;
            mdo_d   = op_q ? 1'b1 : tx_q[31];
          end else begin
            cnt_d = cnt_q + 7'd1;
            mdo_d = tx_q[31];
          end
        end
      end
      S_TA: begin
        if (end_slot) begin
          tx_d  = {tx_q[30:0], 1'b0};
          mdo_d = op_q ? 1'b1 : tx_q[31];
          if (cnt_q == 7'd1) begin
            // A released bus reads back as 1 here: nobody answered the read.
            ta_err_d = op_q & sync2_q;
            state_d  = S_DATA;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      S_DATA: begin
        if (end_slot) begin
          rx_d = {rx_q[14:0], sync2_q};
          if (cnt_q == 7'd15) begin
            state_d = S_IDLE_SLOT;
            mdo_d   = 1'b1;
            oe_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 7'd1;
            mdo_d = op_q ? 1'b1 : tx_q[31];
            tx_d  = {tx_q[30:0], 1'b0};
          end
        end
      end
      S_IDLE_SLOT: begin
        if (end_slot) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rdata_d     = op_q ? rx_q : 16'h0000;
          rerr_d      = op_q & ta_err_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase

    mdc_d = (state_d != S_IDLE) && (state_d != S_DONE) && (ph_d >= PH_HALF);
  end

  assign mdc           = mdc_q;
  assign mdio_o        = mdo_q;
  assign mdio_oe       = oe_q;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rerr_q;

endmodule
